// File: rtl/twiddle_gen.sv
// twiddle_gen -- pipelined FFT twiddle-factor generator.
//
// Returns W_N^(k*n) = cos(2*pi*k*n/N) - j*sin(2*pi*k*n/N) for a runtime N = 2^log2n
// (log2n clamped to MAX_LOG2N). A quarter-wave table plus quadrant folding
// supplies the factor; there is no divider in the address path.
//
// Pipeline (global enable en = !out_valid || out_ready, in_ready = en):
//   S1  index = (k*n mod 2^L) scaled to the MAX_LOG2N-bit phase circle
//   S2  synchronous table read, quadrant/tag delayed alongside
//   S3  quadrant fold / negation into the output registers
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       request handshake
//   in_log2n, in_k, in_n    log2 N, indices k and n
//   in_tag                  user tag, returned with the result
//   in_inv                  (TWIDDLE_CONJ_EN only) return the conjugate
//   out_valid/out_ready     result handshake
//   out_re, out_im          signed Q1.(DW-1) result
//   out_tag                 tag of the producing request
//
// Optional feature macro: TWIDDLE_CONJ_EN adds in_inv; when set on a request
// the imaginary part is negated (inverse-FFT twiddle). Latency is unchanged.
//
// Table content: word j = {cos, sin} of 2*pi*j/2^MAX_LOG2N, j < 2^(MAX_LOG2N-2),
// rounded to DW bits and saturated at 2^(DW-1)-1. It is computed at elaboration
// with integer-only arithmetic so the netlist needs no external image; INIT_FILE
// names the equivalent image used by board-level flows. Requires DW <= 32.

module twiddle_gen #(
  parameter int DW        = 16,
  parameter int MAX_LOG2N = 12,
  parameter int TAG_W     = 8,
  parameter     INIT_FILE = "twiddle_quarter.hex"
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(MAX_LOG2N+1)-1:0] in_log2n,
  input  logic [MAX_LOG2N-1:0]           in_k,
  input  logic [MAX_LOG2N-1:0]           in_n,
`ifdef TWIDDLE_CONJ_EN
  input  logic                           in_inv,
`endif
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW-1:0]                  out_re,
  output logic [DW-1:0]                  out_im,
  output logic [TAG_W-1:0]               out_tag
);

  localparam int M      = MAX_LOG2N;
  localparam int LW     = $clog2(MAX_LOG2N+1);
  localparam int JW     = M - 2;
  localparam int Q      = 1 << JW;
  localparam int STAGES = 3;
  localparam int F      = 30;  // fractional bits of the elaboration-time math

  // Integer Taylor-series sin/cos of (pi/2)*j/Q, rounded to DW bits.
  function automatic logic [2*DW-1:0] rom_word(input int j);
    longint pi_f, x, x2, t, s, c, sv, cv;
    pi_f = 64'd3373259426;  // round(pi * 2^30)
    x    = (pi_f * longint'(j)) / longint'(2*Q);
    x2   = (x * x) >>> F;
    s = x;
    t = x;
    for (int i = 1; i <= 12; i++) begin
      t = -((t * x2) >>> F) / longint'((2*i) * (2*i+1));
      s = s + t;
    end
    c = longint'(1) << F;
    t = longint'(1) << F;
    for (int i = 1; i <= 12; i++) begin
      t = -((t * x2) >>> F) / longint'((2*i-1) * (2*i));
      c = c + t;
    end
    cv = ((c << (DW-1)) + (longint'(1) << (F-1))) >>> F;
    sv = ((s << (DW-1)) + (longint'(1) << (F-1))) >>> F;
    // Anything that rounds to +1.0 saturates so negation can never overflow.
    if (cv > (longint'(1) << (DW-1)) - 1) cv = (longint'(1) << (DW-1)) - 1;
    if (sv > (longint'(1) << (DW-1)) - 1) sv = (longint'(1) << (DW-1)) - 1;
    if (cv < 0) cv = 0;
    if (sv < 0) sv = 0;
    return {cv[DW-1:0], sv[DW-1:0]};
  endfunction

  logic [2*DW-1:0] rom [Q];

  for (genvar g = 0; g < Q; g++) begin : g_rom
    localparam logic [2*DW-1:0] WORD = rom_word(g);
    assign rom[g] = WORD;
  end

  // ---------------------------------------------------------------- control
  logic              en, acc;
  logic [STAGES:1]   vld_pipe;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign acc       = in_valid && en;
  assign out_valid = vld_pipe[STAGES];

  // ---------------------------------------------------------------- S1 math
  logic [LW-1:0] l_clamp, shamt;
  logic [M-1:0]  prod_lo, idx;

  assign l_clamp = (in_log2n > LW'(M)) ? LW'(M) : in_log2n;
  assign shamt   = LW'(M) - l_clamp;
  // The low M bits of k*n are exact modulo 2^M, and 2^L divides 2^M, so they
  // carry every bit of (k*n mod 2^L). Shifting left by M-L drops the bits at
  // and above L, which performs the modulo and the scaling in one step.
  assign prod_lo = in_k * in_n;
  assign idx     = prod_lo << shamt;

  // ---------------------------------------------------------------- datapath
  logic [M-1:0]     idx1;
  logic [TAG_W-1:0] tag1, tag2;
  logic [1:0]       q2;
  logic [2*DW-1:0]  rom_q;
  logic             inv_s1, inv_s2;

`ifdef TWIDDLE_CONJ_EN
  assign inv_s1 = in_inv;
`else
  assign inv_s1 = 1'b0;
`endif

  logic inv1;

  always_ff @(posedge clk) begin
    if (en) begin
      idx1  <= idx;
      tag1  <= in_tag;
      inv1  <= inv_s1;
      rom_q <= rom[idx1[JW-1:0]];
      q2    <= idx1[M-1:M-2];
      tag2  <= tag1;
      inv_s2 <= inv1;
    end
  end

  // ---------------------------------------------------------------- S3 fold
  logic [DW-1:0] c, s, re_n, im_f, im_n;

  assign c = rom_q[2*DW-1:DW];
  assign s = rom_q[DW-1:0];

  always_comb begin
    re_n = c;
    im_f = -s;
    case (q2)
      2'd0: begin re_n = c;  im_f = -s; end
      2'd1: begin re_n = -s; im_f = -c; end
      2'd2: begin re_n = -c; im_f = s;  end
      2'd3: begin re_n = s;  im_f = c;  end
      default: ;
    endcase
    im_n = inv_s2 ? -im_f : im_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      out_re   <= '0;
      out_im   <= '0;
      out_tag  <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      out_re   <= re_n;
      out_im   <= im_n;
      out_tag  <= tag2;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: directed vector table with exact expectations, an 8-deep
// burst with a mid-burst stall, a reset-in-flight sequence and a randomised
// stream checked against a trigonometric reference model (+/-1 LSB).
module tb_twiddle_gen;

  localparam int DW = 16;
  localparam int M  = 12;
  localparam int TW = 8;
  localparam int LW = 4;
  localparam real PI = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_log2n = '0;
  logic [M-1:0]  in_k = '0;
  logic [M-1:0]  in_n = '0;
  logic          in_inv = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re, out_im;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  twiddle_gen #(.DW(DW), .MAX_LOG2N(M), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_log2n (in_log2n),
    .in_k     (in_k),
    .in_n     (in_n),
`ifdef TWIDDLE_CONJ_EN
    .in_inv   (in_inv),
`endif
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_tag  (out_tag)
  );

  typedef struct {
    logic [LW-1:0] log2n;
    logic [M-1:0]  k;
    logic [M-1:0]  n;
    logic [TW-1:0] tag;
    logic          inv;
  } req_t;

  typedef struct {
    req_t          r;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  req_t sb[$];
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_re, hold_im;
  logic [TW-1:0] hold_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int exp);
    n_vec++;
    if (act - exp > 1 || exp - act > 1) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (+/-1)", nm, act, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  // Reference: W = exp(-j*2*pi*(k*n mod N)/N), conjugated when inv is set.
  function automatic void model(input req_t r, output int re, output int im);
    int     l;
    longint prod, p, nn;
    real    a;
    l    = (r.log2n > 4'(M)) ? M : int'(r.log2n);
    nn   = longint'(1) << l;
    prod = longint'(r.k) * longint'(r.n);
    p    = prod % nn;
    a    = 2.0 * PI * real'(p) / real'(nn);
    re   = sat(rnd($cos(a) * 32768.0));
    im   = sat(rnd(-$sin(a) * 32768.0));
    if (r.inv) im = -im;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 unit later.
  task automatic step(input logic v, input req_t r, input logic ordy, output logic acc);
    req_t e;
    int   er, ei;
    @(negedge clk);
    in_valid  = v;
    in_log2n  = r.log2n;
    in_k      = r.k;
    in_n      = r.n;
    in_tag    = r.tag;
    in_inv    = r.inv;
    out_ready = ordy;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_re", 32'(out_re), 32'(hold_re));
      chk("hold_im", 32'(out_im), 32'(hold_im));
      chk("hold_tag", 32'(out_tag), 32'(hold_tag));
    end
    if (out_valid && !ordy) chk("stall_in_ready", 32'(in_ready), 32'd0);
    acc = v && in_ready;
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got tag 0x%0h, expected no result", out_tag);
      end else begin
        e = sb.pop_front();
        model(e, er, ei);
        chk("tag", 32'(out_tag), 32'(e.tag));
        chk_near("re", int'($signed(out_re)), er);
        chk_near("im", int'($signed(out_im)), ei);
      end
    end
    if (acc) sb.push_back(r);
    hold_pend = out_valid && !ordy;
    hold_re   = out_re;
    hold_im   = out_im;
    hold_tag  = out_tag;
  endtask

  task automatic drain();
    req_t z;
    logic a;
    z = '{default: '0};
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(1'b0, z, 1'b1, a);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
    end
    for (int i = 0; i < 4; i++) step(1'b0, z, 1'b1, a);
  endtask

  function automatic vec_t mk(input int l, input int k, input int n, input int tag,
                              input bit inv, input int re, input int im);
    vec_t v;
    v.r.log2n = LW'(l);
    v.r.k     = M'(k);
    v.r.n     = M'(n);
    v.r.tag   = TW'(tag);
    v.r.inv   = inv;
    v.re      = DW'(re);
    v.im      = DW'(im);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    req_t z, r;
    logic a;
    int   issued, cyc;
    bit   pend;

    z = '{default: '0};

    // -------------------------------------------------- reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // -------------------------------------------------- directed table
    tbl.push_back(mk(12, 0, 0, 'h11, 0, 'h7FFF, 'h0000));
    tbl.push_back(mk(12, 1, 1024, 'h22, 0, 'h0000, 'h8001));
    tbl.push_back(mk(3, 3, 5, 'h33, 0, 'h5A82, 'h5A82));
    tbl.push_back(mk(13, 1, 1024, 'h44, 0, 'h0000, 'h8001));
    tbl.push_back(mk(0, 5, 7, 'h55, 0, 'h7FFF, 'h0000));
    tbl.push_back(mk(12, 1, 2048, 'h66, 0, 'h8001, 'h0000));
    tbl.push_back(mk(12, 1, 3072, 'h77, 0, 'h0000, 'h7FFF));
    tbl.push_back(mk(15, 4095, 4095, 'h88, 0, 'h7FFF, 'hFFCE));
    tbl.push_back(mk(1, 1, 1, 'h99, 0, 'h8001, 'h0000));
    tbl.push_back(mk(2, 3, 1, 'hAA, 0, 'h0000, 'h7FFF));
`ifdef TWIDDLE_CONJ_EN
    tbl.push_back(mk(12, 1, 1024, 'hBB, 1, 'h0000, 'h7FFF));
    tbl.push_back(mk(12, 1, 1024, 'hCC, 0, 'h0000, 'h8001));
`endif

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].r, 1'b1, a);
      chk("accept", 32'(a), 32'd1);
      step(1'b0, z, 1'b1, a);
      step(1'b0, z, 1'b1, a);
      chk("lat_early", 32'(out_valid), 32'd0);
      step(1'b0, z, 1'b1, a);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("vec_re", 32'(out_re), 32'(tbl[i].re));
      chk("vec_im", 32'(out_im), 32'(tbl[i].im));
      chk("vec_tag", 32'(out_tag), 32'(tbl[i].r.tag));
      step(1'b0, z, 1'b1, a);
      chk("no_dup", 32'(out_valid), 32'd0);
    end

    // -------------------------------------------------- burst with stall
    issued = 0;
    cyc = 0;
    while (issued < 8 && cyc < 100) begin
      r.log2n = LW'($urandom_range(0, 15));
      r.k     = M'($urandom);
      r.n     = M'($urandom);
      r.tag   = TW'(issued);
      r.inv   = 1'b0;
      step(1'b1, r, !(cyc >= 4 && cyc < 9), a);
      if (a) issued++;
      cyc++;
    end
    drain();

    // -------------------------------------------------- reset in flight
    r = '{log2n: 4'd12, k: 12'd1, n: 12'd512, tag: 8'hD1, inv: 1'b0};
    step(1'b1, r, 1'b1, a);
    r.tag = 8'hD2;
    step(1'b1, r, 1'b1, a);
    step(1'b0, z, 1'b0, a);
    step(1'b0, z, 1'b0, a);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_tag", 32'(out_tag), 32'd0);
    sb.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, z, 1'b1, a);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end
    r.tag = 8'hD3;
    step(1'b1, r, 1'b1, a);
    drain();

    // -------------------------------------------------- random stream
    pend = 0;
    issued = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        r.log2n = LW'($urandom_range(0, 15));
        r.k     = M'($urandom);
        r.n     = M'($urandom);
        r.tag   = TW'(issued);
`ifdef TWIDDLE_CONJ_EN
        r.inv   = 1'($urandom);
`else
        r.inv   = 1'b0;
`endif
        pend = 1;
      end
      step(pend, r, ($urandom_range(0, 9) < 6), a);
      if (a) begin
        pend = 0;
        issued++;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
Parametrised, pipelined twiddle-factor generator for the FFT datapath. It returns W_N^(k*n) = cos(2*pi*k*n/N) - j*sin(2*pi*k*n/N) for a runtime-selectable N = 2^log2n. The factor comes from a quarter-wave ROM plus quadrant symmetry, with no divider in the address path. It uses a valid/ready handshake on both sides and carries a user tag so butterfly units can match each factor to its operand.

Parameters:
DW, 16, bits per component (re, im), signed Q1.(DW-1)
MAX_LOG2N, 12, log2 of largest supported N; ROM depth Q = 2^(MAX_LOG2N-2)
TAG_W, 8, width of pass-through tag
INIT_FILE, "twiddle_quarter.hex", ROM image; word j = {cos(2*pi*j/2^MAX_LOG2N), sin(same)}, each DW bits, j = 0..Q-1, cos(0) stored saturated as 2^(DW-1)-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_log2n  in  $clog2(MAX_LOG2N+1)  log2 of N for this request
in_k  in  MAX_LOG2N  index k
in_n  in  MAX_LOG2N  index n
in_tag  in  TAG_W  user tag
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_re  out  DW  real part, signed
out_im  out  DW  imag part, signed
out_tag  out  TAG_W  tag of the request that produced this result

Behaviour:
- Single clock clk; reset asynchronous, active-low (rst_n). While rst_n=0: all stage valids, out_valid, out_re, out_im and out_tag are 0. in_ready is 1 after reset.
- Three-stage pipeline with global enable en = !out_valid || out_ready; in_ready = en.
- S1 (on accept): L = min(in_log2n, MAX_LOG2N); p = (in_k*in_n) mod 2^L, i.e. the low L bits of the full 2*MAX_LOG2N product. idx = p << (MAX_LOG2N-L), MAX_LOG2N bits. Register idx, tag and valid.
- S2: synchronous ROM read at j = idx[MAX_LOG2N-3:0]; delay q = idx[MAX_LOG2N-1:MAX_LOG2N-2], tag and valid.
- S3: with c, s from ROM:
  - q0: re=c, im=-s
  - q1: re=-s, im=-c
  - q2: re=-c, im=s
  - q3: re=s, im=c
  - Negation is two's complement; it cannot overflow because stored values are at most 2^(DW-1)-1.
- Latency is exactly 3 clk from accept to out_valid when out_ready stays 1. Throughput is 1 result per cycle.
- Stall: when en=0, every stage register, including the ROM output register, holds. Outputs stay stable while out_valid && !out_ready. Bubbles propagate as valid=0.
- Results leave in request order; no loss or duplication under any out_ready pattern.
- log2n=0 gives N=1, idx=0, result (max,0). log2n > MAX_LOG2N clamps to MAX_LOG2N.
- k*n wraps modulo N; the full product is never truncated before the modulo.
- Reset mid-operation: all in-flight requests are discarded. No result appears after rst_n deasserts until new requests are accepted.

Optional Feature:
TWIDDLE_CONJ_EN
- Defined: adds input port in_inv (1 bit), sampled on accept and carried down the pipeline. When it is 1, S3 negates im, producing the conjugate W_N^(-k*n) for the inverse FFT. Latency is unchanged.
- Undefined: port in_inv is absent; forward twiddles only; logic identical to in_inv=0.

Test Plan:
- Reset, DW=16, MAX_LOG2N=12, out_ready=1; log2n=12, k=0, n=0, tag=0x11 -> 3 cycles later out_valid=1, re=0x7FFF, im=0x0000, tag=0x11.
- log2n=12, k=1, n=1024 (q1, j=0) -> re=0x0000, im=0x8001.
- log2n=3, k=3, n=5 (15 mod 8 = 7, idx=3584) -> re=0x5A82, im=0x5A82; log2n=13, k=1, n=1024 -> same as the previous scenario (clamp).
- Back-to-back burst of 8 requests (tags 0..7), out_ready low for 5 cycles mid-burst -> in_ready low during the stall, outputs held stable, tags 0..7 in order, no duplicates, values match the model.
- Two requests in flight, pulse rst_n low for 1 cycle -> out_valid drops to 0 asynchronously; no output after release until the next accept.
- With TWIDDLE_CONJ_EN: in_inv=1, log2n=12, k=1, n=1024 -> re=0x0000, im=0x7FFF; same request with in_inv=0 -> im=0x8001.
